banco_de_registradores_param: RTL and testbench
===============================================

BANCO_DE_REGISTRADORES_PARAM -- requirements
Module: banco_de_registradores_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named Clock and Reset.
REQ-002 The block SHALL take parameter WIDTH, default 8: data width in bits of every register.
REQ-003 The block SHALL take parameter DEPTH, default 8: number of registers, a power of two, at least 2.
REQ-004 The block SHALL take parameter ZERO_REG, default 0: if 1, register 0 always reads zero and ignores writes.
REQ-005 The block SHALL derive ADDR_W = log2(DEPTH) and not expose it as a user parameter.
REQ-006 The block SHALL have port Clock, input, 1 bit: clock; all state updates on its rising edge.
REQ-007 The block SHALL have port Reset, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port RegLido1, input, ADDR_W bits: read address, port 1.
REQ-009 The block SHALL have port RegLido2, input, ADDR_W bits: read address, port 2.
REQ-010 The block SHALL have port RegEscr, input, ADDR_W bits: write address.
REQ-011 The block SHALL have port DadoEscr, input, WIDTH bits: write data.
REQ-012 The block SHALL have port RegWrite, input, 1 bit: write enable.
REQ-013 The block SHALL have port Limpar, input, 1 bit: clear-sweep request, sampled as a level.
REQ-014 The block SHALL have port Dado1, output, WIDTH bits: registered read data, port 1.
REQ-015 The block SHALL have port Dado2, output, WIDTH bits: registered read data, port 2.
REQ-016 The block SHALL have port Ocupado, output, 1 bit: high while the clear sweep is running.

Function
REQ-017 Write: when RegWrite=1 and state is OCIOSO, BR[RegEscr] SHALL take DadoEscr at the rising edge; when ZERO_REG=1 and RegEscr=0, the write SHALL be discarded.
REQ-018 Read: Dado1/Dado2 SHALL be registered; they take the content of BR[RegLido1]/BR[RegLido2] at the same rising edge, one-cycle latency.
REQ-019 Bypass: if a write to address A, user or sweep, takes effect at an edge and RegLido1 or RegLido2 equals A, that port SHALL capture the written value (write-first).
REQ-020 When ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-021 Both read ports SHALL operate independently; equal addresses SHALL return identical data.
REQ-022 The FSM SHALL have exactly two states, OCIOSO and LIMPANDO, plus an ADDR_W-bit sweep counter.
REQ-023 In OCIOSO with Limpar=1, the next state SHALL be LIMPANDO with counter=0; a RegWrite in that same cycle SHALL still be performed.
REQ-024 In LIMPANDO, each cycle SHALL write 0 to BR[counter] and increment the counter; at counter=DEPTH-1 that register SHALL be cleared and the state SHALL return to OCIOSO; the sweep takes exactly DEPTH cycles.
REQ-025 In LIMPANDO, RegWrite SHALL be ignored and Limpar SHALL be ignored; reads SHALL remain active with the REQ-019 bypass.
REQ-026 Ocupado SHALL equal 1 exactly when the state is LIMPANDO, and is a registered output.
REQ-027 A Limpar held high continuously SHALL start a new sweep on the first OCIOSO cycle after the previous sweep completes.

Reset
REQ-028 With Reset=1 at a rising edge, all BR entries, Dado1, Dado2, Ocupado and the counter SHALL become 0 and the state SHALL become OCIOSO.
REQ-029 Reset SHALL take priority over RegWrite, Limpar and the sweep; asserting Reset mid-sweep SHALL abort it, with all registers zero afterwards.

Verification
REQ-030 Directed test: after reset, write i+1 to register i for i=0..7, then read pairs (j,7-j) -> Dado1=j+1 and Dado2=8-j, one cycle after each address is applied.
REQ-031 Directed test: RegWrite=1, RegEscr=3, DadoEscr=0xA5, RegLido1=3 in the same cycle -> Dado1=0xA5 after that edge; no stale value.
REQ-032 Directed test: ZERO_REG=1, write 0xFF to register 0 -> Dado1=0x00 when reading register 0.
REQ-033 Directed test: registers loaded with nonzero values, pulse Limpar one cycle -> Ocupado=1 for exactly 8 cycles; RegWrite of 0x55 to register 5 mid-sweep is ignored; all reads return 0 afterwards.
REQ-034 Directed test: Reset asserted on the 3rd sweep cycle -> next edge Ocupado=0, state OCIOSO, all registers read 0.
REQ-035 Directed test: WIDTH=16, DEPTH=32 -> write 0xBEEF to register 31, read on both ports -> Dado1=Dado2=0xBEEF.

Source files
------------

// File: rtl/banco_de_registradores_param.sv
// Parameterised register bank: two registered read ports with write-first bypass,
// one write port, and a background clear sweep that zeroes every entry in DEPTH cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OCIOSO   | idle: user writes accepted, Limpar starts a sweep
// LIMPANDO | sweeping: BR[contador] <= 0 each cycle, user writes ignored
module banco_de_registradores_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [$clog2(DEPTH)-1:0] RegLido1,
  input  logic [$clog2(DEPTH)-1:0] RegLido2,
  input  logic [$clog2(DEPTH)-1:0] RegEscr,
  input  logic [WIDTH-1:0]         DadoEscr,
  input  logic                     RegWrite,
  input  logic                     Limpar,
  output logic [WIDTH-1:0]         Dado1,
  output logic [WIDTH-1:0]         Dado2,
  output logic                     Ocupado
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);

  typedef enum logic {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;

  estado_t           estado;
  logic [ADDR_W-1:0] contador;
  logic [WIDTH-1:0]  br [DEPTH];

  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic [WIDTH-1:0]  proxDado1;
  logic [WIDTH-1:0]  proxDado2;

  // A single write source per edge: the sweep owns the port while it runs.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = RegEscr;
    wrData = DadoEscr;
    if (estado == LIMPANDO) begin
      wrEn   = 1'b1;
      wrAddr = contador;
      wrData = '0;
    end else if (RegWrite && !(ZERO_REG && RegEscr == '0)) begin
      wrEn = 1'b1;
    end
  end

  always_comb begin
    proxDado1 = br[RegLido1];
    proxDado2 = br[RegLido2];
    if (wrEn && wrAddr == RegLido1) proxDado1 = wrData;
    if (wrEn && wrAddr == RegLido2) proxDado2 = wrData;
    if (ZERO_REG && RegLido1 == '0) proxDado1 = '0;
    if (ZERO_REG && RegLido2 == '0) proxDado2 = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) br[i] <= '0;
      Dado1    <= '0;
      Dado2    <= '0;
      Ocupado  <= 1'b0;
      contador <= '0;
      estado   <= OCIOSO;
    end else begin
      if (wrEn) br[wrAddr] <= wrData;
      Dado1 <= proxDado1;
      Dado2 <= proxDado2;
      case (estado)
        OCIOSO: begin
          if (Limpar) begin
            estado   <= LIMPANDO;
            contador <= '0;
            Ocupado  <= 1'b1;
          end
        end
        LIMPANDO: begin
          contador <= contador + 1'b1;
          if (contador == ULTIMO) begin
            estado  <= OCIOSO;
            Ocupado <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banco_de_registradores_param.sv
// Scoreboard bench for banco_de_registradores_param: default bank, ZERO_REG bank
// and a 16x32 bank share one clock; expectations queue up as stimulus is applied.
module tb_banco_de_registradores_param;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // bank A: 8x8, ZERO_REG=0
  logic       rstA, wrA, limpA, ocupA;
  logic [2:0] lidoA1, lidoA2, escrA;
  logic [7:0] dadoA, outA1, outA2;
  // bank B: 8x8, ZERO_REG=1
  logic       rstB, wrB, limpB, ocupB;
  logic [2:0] lidoB1, lidoB2, escrB;
  logic [7:0] dadoB, outB1, outB2;
  // bank C: 16x32
  logic        rstC, wrC, limpC, ocupC;
  logic [4:0]  lidoC1, lidoC2, escrC;
  logic [15:0] dadoC, outC1, outC2;

  banco_de_registradores_param dutA (
    .Clock(Clock), .Reset(rstA), .RegLido1(lidoA1), .RegLido2(lidoA2), .RegEscr(escrA),
    .DadoEscr(dadoA), .RegWrite(wrA), .Limpar(limpA), .Dado1(outA1), .Dado2(outA2),
    .Ocupado(ocupA));

  banco_de_registradores_param #(.ZERO_REG(1'b1)) dutB (
    .Clock(Clock), .Reset(rstB), .RegLido1(lidoB1), .RegLido2(lidoB2), .RegEscr(escrB),
    .DadoEscr(dadoB), .RegWrite(wrB), .Limpar(limpB), .Dado1(outB1), .Dado2(outB2),
    .Ocupado(ocupB));

  banco_de_registradores_param #(.WIDTH(16), .DEPTH(32)) dutC (
    .Clock(Clock), .Reset(rstC), .RegLido1(lidoC1), .RegLido2(lidoC2), .RegEscr(escrC),
    .DadoEscr(dadoC), .RegWrite(wrC), .Limpar(limpC), .Dado1(outC1), .Dado2(outC2),
    .Ocupado(ocupC));

  typedef struct {
    int          sel;
    string       tag;
    bit          chkD;
    bit          chkO;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eo;
  } esp_t;

  esp_t fila[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mdl [8];

  task automatic confere(input string tag, input logic [15:0] obs, input logic [15:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic passo(input int sel, input string tag, input bit chkD, input bit chkO,
                       input logic [15:0] e1, input logic [15:0] e2, input logic eo);
    esp_t ent;
    logic [15:0] o1, o2;
    logic        oo;
    ent.sel = sel; ent.tag = tag; ent.chkD = chkD; ent.chkO = chkO;
    ent.e1 = e1; ent.e2 = e2; ent.eo = eo;
    fila.push_back(ent);
    @(posedge Clock);
    #1;
    ent = fila.pop_front();
    case (ent.sel)
      0:       begin o1 = {8'h00, outA1}; o2 = {8'h00, outA2}; oo = ocupA; end
      1:       begin o1 = {8'h00, outB1}; o2 = {8'h00, outB2}; oo = ocupB; end
      default: begin o1 = outC1;          o2 = outC2;          oo = ocupC; end
    endcase
    if (ent.chkD) begin
      confere({ent.tag, ".d1"}, o1, ent.e1);
      confere({ent.tag, ".d2"}, o2, ent.e2);
    end
    if (ent.chkO) confere({ent.tag, ".ocup"}, {15'h0, oo}, {15'h0, ent.eo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstA = 1; wrA = 0; limpA = 0; lidoA1 = 0; lidoA2 = 0; escrA = 0; dadoA = 0;
    rstB = 1; wrB = 0; limpB = 0; lidoB1 = 0; lidoB2 = 0; escrB = 0; dadoB = 0;
    rstC = 1; wrC = 0; limpC = 0; lidoC1 = 0; lidoC2 = 0; escrC = 0; dadoC = 0;

    passo(0, "resetA", 1, 1, 16'h0, 16'h0, 1'b0);
    passo(1, "resetB", 1, 1, 16'h0, 16'h0, 1'b0);
    passo(2, "resetC", 1, 1, 16'h0, 16'h0, 1'b0);
    rstA = 0; rstB = 0; rstC = 0;

    // fill register i with i+1, then read mirrored pairs
    for (int i = 0; i < 8; i++) begin
      wrA = 1; escrA = 3'(i); dadoA = 8'(i + 1); mdl[i] = 8'(i + 1);
      passo(0, "carga", 0, 1, 16'h0, 16'h0, 1'b0);
    end
    wrA = 0;
    for (int j = 0; j < 8; j++) begin
      lidoA1 = 3'(j); lidoA2 = 3'(7 - j);
      passo(0, $sformatf("par%0d", j), 1, 0, 16'(j + 1), 16'(8 - j), 1'b0);
    end
    lidoA1 = 4; lidoA2 = 4;
    passo(0, "iguais", 1, 0, 16'd5, 16'd5, 1'b0);

    // write and read same address in one cycle
    wrA = 1; escrA = 3; dadoA = 8'hA5; lidoA1 = 3; lidoA2 = 2;
    passo(0, "bypass", 1, 0, 16'h00A5, 16'h0003, 1'b0);
    mdl[3] = 8'hA5;

    // sweep start also accepts a write in that cycle
    limpA = 1; wrA = 1; escrA = 6; dadoA = 8'h77; lidoA1 = 1; lidoA2 = 6;
    passo(0, "inicio", 1, 1, 16'h0002, 16'h0077, 1'b1);
    mdl[6] = 8'h77;
    limpA = 0; wrA = 0;
    for (int k = 0; k < 8; k++) begin
      lidoA1 = 3'(k); lidoA2 = 3'((k + 1) % 8);
      wrA = (k == 2); escrA = 5; dadoA = 8'h55;
      limpA = (k == 4);
      passo(0, $sformatf("varre%0d", k), 1, 1, 16'h0, {8'h00, mdl[(k + 1) % 8]}, k != 7);
      mdl[k] = 8'h00;
    end
    wrA = 0; limpA = 0;
    for (int j = 0; j < 8; j++) begin
      lidoA1 = 3'(j); lidoA2 = 3'(7 - j);
      passo(0, $sformatf("limpo%0d", j), 1, 1, 16'h0, 16'h0, 1'b0);
    end

    // Limpar held: one idle cycle between back-to-back sweeps
    limpA = 1;
    for (int n = 0; n < 10; n++)
      passo(0, $sformatf("retido%0d", n), 0, 1, 16'h0, 16'h0, n != 8);
    limpA = 0;
    for (int n = 0; n < 8; n++)
      passo(0, $sformatf("fim%0d", n), 0, 1, 16'h0, 16'h0, n != 7);

    // reset on the third sweep cycle
    for (int i = 0; i < 8; i++) begin
      wrA = 1; escrA = 3'(i); dadoA = 8'(8'h10 + i);
      passo(0, "recarga", 0, 0, 16'h0, 16'h0, 1'b0);
    end
    wrA = 0; limpA = 1; lidoA1 = 3; lidoA2 = 7;
    passo(0, "rsInicio", 1, 1, 16'h0013, 16'h0017, 1'b1);
    limpA = 0;
    passo(0, "rsK0", 0, 1, 16'h0, 16'h0, 1'b1);
    passo(0, "rsK1", 0, 1, 16'h0, 16'h0, 1'b1);
    rstA = 1;
    passo(0, "rsK2", 1, 1, 16'h0, 16'h0, 1'b0);
    rstA = 0;
    for (int j = 0; j < 8; j++) begin
      lidoA1 = 3'(j); lidoA2 = 3'(7 - j);
      passo(0, $sformatf("posRst%0d", j), 1, 1, 16'h0, 16'h0, 1'b0);
    end

    // reset beats a simultaneous write and Limpar
    rstA = 1; wrA = 1; escrA = 2; dadoA = 8'h33; limpA = 1; lidoA1 = 2; lidoA2 = 2;
    passo(0, "rstPrio", 1, 1, 16'h0, 16'h0, 1'b0);
    rstA = 0; wrA = 0; limpA = 0;
    passo(0, "rstPrio2", 1, 1, 16'h0, 16'h0, 1'b0);

    // ZERO_REG bank
    wrB = 1; escrB = 0; dadoB = 8'hFF; lidoB1 = 0; lidoB2 = 0;
    passo(1, "zeroByp", 1, 1, 16'h0, 16'h0, 1'b0);
    escrB = 1; dadoB = 8'h11; lidoB1 = 0; lidoB2 = 1;
    passo(1, "zeroW1", 1, 0, 16'h0, 16'h0011, 1'b0);
    wrB = 0;
    passo(1, "zeroLe", 1, 0, 16'h0, 16'h0011, 1'b0);

    // wide bank
    wrC = 1; escrC = 31; dadoC = 16'hBEEF; lidoC1 = 31; lidoC2 = 31;
    passo(2, "largoByp", 1, 0, 16'hBEEF, 16'hBEEF, 1'b0);
    escrC = 0; dadoC = 16'h1234; lidoC1 = 0; lidoC2 = 31;
    passo(2, "largoW0", 1, 0, 16'h1234, 16'hBEEF, 1'b0);
    wrC = 0; lidoC1 = 31; lidoC2 = 31;
    passo(2, "largo", 1, 1, 16'hBEEF, 16'hBEEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
